// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the memory-side bus of dmem_arbiter.
// The arbiter uses the slave view; requesters and memory use the master view.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              p0_req,   p1_req;
   logic              p0_we,    p1_we;
   logic              p0_lock,  p1_lock;
   logic [ADDR_W-1:0] p0_addr,  p1_addr;
   logic [DATA_W-1:0] p0_wdata, p1_wdata;
   logic              p0_gnt,   p1_gnt;
   logic              p0_rvalid, p1_rvalid;
   logic [DATA_W-1:0] p0_rdata, p1_rdata;
   logic [ADDR_W-1:0] mem_A;
   logic [DATA_W-1:0] mem_WD;
   logic              mem_WE;
   logic [DATA_W-1:0] mem_RD;
   logic              core_stall;

   modport slave (
      input  p0_req, p1_req, p0_we, p1_we, p0_lock, p1_lock,
             p0_addr, p1_addr, p0_wdata, p1_wdata, mem_RD,
      output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
             mem_A, mem_WD, mem_WE, core_stall
   );

   modport master (
      output p0_req, p1_req, p0_we, p1_we, p0_lock, p1_lock,
             p0_addr, p1_addr, p0_wdata, p1_wdata, mem_RD,
      input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
             mem_A, mem_WD, mem_WE, core_stall
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core (port 0)
// and a debug/loader master (port 1), with lock bursts bounded by MAX_BURST.
module dmem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic           clk,
   input  logic           rst,
   dmem_arbiter_if.slave  bus
);
   localparam int            CW   = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} own_e;

   own_e              owner_q, owner_d;
   logic              last_q, last_d;
   logic [CW-1:0]     burst_q, burst_d;
   logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

   logic g0, g1, gnt_any, gnt_we, gnt_lock;

   // Owner keeps the port until its burst is spent and the other side is waiting.
   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (owner_q == OWN0 && bus.p0_req) begin
         if (burst_q < MAXB || !bus.p1_req) g0 = 1'b1;
         else                                g1 = 1'b1;
      end else if (owner_q == OWN1 && bus.p1_req) begin
         if (burst_q < MAXB || !bus.p0_req) g1 = 1'b1;
         else                                g0 = 1'b1;
      end else if (bus.p0_req && bus.p1_req) begin
         g0 = last_q;
         g1 = !last_q;
      end else begin
         g0 = bus.p0_req;
         g1 = bus.p1_req;
      end
      // Outputs must drop while reset is held, before any clock edge.
      if (!rst) begin
         g0 = 1'b0;
         g1 = 1'b0;
      end
   end

   assign gnt_any  = g0 | g1;
   assign gnt_we   = (g0 & bus.p0_we)   | (g1 & bus.p1_we);
   assign gnt_lock = (g0 & bus.p0_lock) | (g1 & bus.p1_lock);

   assign bus.p0_gnt     = g0;
   assign bus.p1_gnt     = g1;
   assign bus.mem_WE     = gnt_we;
   assign bus.mem_A      = g0 ? bus.p0_addr  : (g1 ? bus.p1_addr  : '0);
   assign bus.mem_WD     = g0 ? bus.p0_wdata : (g1 ? bus.p1_wdata : '0);
   assign bus.core_stall = rst & bus.p0_req & ~g0;
   assign bus.p0_rvalid  = rvalid0_q;
   assign bus.p1_rvalid  = rvalid1_q;
   assign bus.p0_rdata   = rdata0_q;
   assign bus.p1_rdata   = rdata1_q;

   always_comb begin
      last_d  = last_q;
      owner_d = IDLE;
      burst_d = '0;
      if (gnt_any) begin
         last_d = g1;
         if (gnt_lock) begin
            owner_d = g1 ? OWN1 : OWN0;
            if (owner_q == owner_d)
               burst_d = (burst_q == MAXB) ? MAXB : burst_q + 1'b1;
            else
               burst_d = CW'(1);
         end
      end
      rvalid0_d = g0 & ~bus.p0_we;
      rvalid1_d = g1 & ~bus.p1_we;
      rdata0_d  = rvalid0_d ? bus.mem_RD : rdata0_q;
      rdata1_d  = rvalid1_d ? bus.mem_RD : rdata1_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q   <= IDLE;
         last_q    <= 1'b1;
         burst_q   <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         owner_q   <= owner_d;
         last_q    <= last_d;
         burst_q   <= burst_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a word-addressed memory model sits on the memory
// bus, and each step compares outputs against hand-computed values.
module tb_dmem_arbiter;
   logic clk, rst;
   int   n_pass = 0;
   int   n_total = 0;
   int   n_fail = 0;

   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] mem [0:255];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.mem_RD = mem[bus.mem_A[9:2]];
   always @(posedge clk) if (bus.mem_WE) mem[bus.mem_A[9:2]] <= bus.mem_WD;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $display("FAIL %s: observed %h required %h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      bus.p0_req = 0; bus.p0_we = 0; bus.p0_lock = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
      bus.p1_req = 0; bus.p1_we = 0; bus.p1_lock = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
      idle_all();
      rst = 1'b0;

      // reset: outputs quiet even with a pending core request
      #1 bus.p0_req = 1;
      #1;
      chk("rst_p0_gnt", {31'd0, bus.p0_gnt}, 32'd0);
      chk("rst_stall", {31'd0, bus.core_stall}, 32'd0);
      chk("rst_memA", bus.mem_A, 32'd0);
      chk("rst_rvalid", {30'd0, bus.p0_rvalid, bus.p1_rvalid}, 32'd0);
      chk("rst_rdata0", bus.p0_rdata, 32'd0);
      bus.p0_req = 0;
      @(negedge clk) rst = 1'b1;

      // simultaneous reads after reset: port 0 first
      tick();
      bus.p0_req = 1; bus.p0_addr = 32'h10;
      bus.p1_req = 1; bus.p1_addr = 32'h20;
      #1;
      chk("c0_p0_gnt", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd1);
      chk("c0_memA", bus.mem_A, 32'h10);
      tick();
      bus.p0_req = 0;
      #1;
      chk("c1_p1_gnt", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd2);
      chk("c1_memA", bus.mem_A, 32'h20);
      chk("c1_p0_rvalid", {31'd0, bus.p0_rvalid}, 32'd1);
      chk("c1_p0_rdata", bus.p0_rdata, 32'hA000_0004);
      tick();
      bus.p1_req = 0;
      #1;
      chk("c2_rvalid", {30'd0, bus.p1_rvalid, bus.p0_rvalid}, 32'd2);
      chk("c2_p1_rdata", bus.p1_rdata, 32'hA000_0008);

      // make last = 0, then contend with a p1 write
      tick();
      bus.p0_req = 1; bus.p0_addr = 32'h0;
      #1 chk("pre_p0_gnt", {31'd0, bus.p0_gnt}, 32'd1);
      tick();
      bus.p0_addr = 32'h40;
      bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 32'h40; bus.p1_wdata = 32'hDEAD_BEEF;
      #1;
      chk("st_gnt", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd2);
      chk("st_memWE", {31'd0, bus.mem_WE}, 32'd1);
      chk("st_memWD", bus.mem_WD, 32'hDEAD_BEEF);
      chk("st_stall", {31'd0, bus.core_stall}, 32'd1);
      tick();
      bus.p1_req = 0; bus.p1_we = 0;
      #1;
      chk("st2_p0_gnt", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd1);
      chk("st2_stall", {31'd0, bus.core_stall}, 32'd0);
      chk("st2_p1_rvalid", {31'd0, bus.p1_rvalid}, 32'd0);
      tick();
      bus.p0_req = 0;
      #1;
      chk("st3_rvalid", {31'd0, bus.p0_rvalid}, 32'd1);
      chk("st3_rdata", bus.p0_rdata, 32'hDEAD_BEEF);

      // bounded burst: last = 0 here, p1 locked, p0 waiting throughout
      bus.p0_req = 1; bus.p0_addr = 32'h04;
      bus.p1_req = 1; bus.p1_lock = 1; bus.p1_addr = 32'h08;
      for (int i = 0; i < 6; i++) begin
         #1 chk($sformatf("burst%0d", i), {30'd0, bus.p1_gnt, bus.p0_gnt}, (i == 4) ? 32'd1 : 32'd2);
         tick();
      end
      idle_all();
      tick();

      // uncontended lock held, then saturated count lets p1 in
      bus.p0_req = 1; bus.p0_lock = 1; bus.p0_addr = 32'h0C;
      for (int i = 0; i < 10; i++) begin
         #1 chk($sformatf("lock%0d", i), {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd1);
         tick();
      end
      bus.p1_req = 1; bus.p1_addr = 32'h0C;
      #1 chk("sat_switch", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd2);
      tick();
      bus.p1_req = 0;
      #1 chk("sat_back", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd1);
      tick();
      idle_all();
      tick();

      // cancelled p1 write while p0 owns the port
      bus.p0_req = 1; bus.p0_lock = 1; bus.p0_addr = 32'h0C;
      #1 chk("cx_p0_gnt", {31'd0, bus.p0_gnt}, 32'd1);
      tick();
      bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 32'h80; bus.p1_wdata = 32'h1234_5678;
      #1;
      chk("cx_p1_gnt_a", {31'd0, bus.p1_gnt}, 32'd0);
      chk("cx_memWE_a", {31'd0, bus.mem_WE}, 32'd0);
      tick();
      #1 chk("cx_p1_gnt_b", {31'd0, bus.p1_gnt}, 32'd0);
      bus.p1_req = 0; bus.p1_we = 0;
      tick();
      #1;
      chk("cx_p1_rvalid", {30'd0, bus.p1_rvalid, bus.p1_gnt}, 32'd0);
      idle_all();
      bus.p1_req = 1; bus.p1_addr = 32'h80;
      #1 chk("cx_rd_gnt", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd2);
      tick();
      bus.p1_req = 0;
      #1;
      chk("cx_rd_rvalid", {31'd0, bus.p1_rvalid}, 32'd1);
      chk("cx_rd_data", bus.p1_rdata, 32'hA000_0020);

      // reset in the cycle after a p0 read grant
      tick();
      bus.p0_req = 1; bus.p0_addr = 32'h10;
      #1 chk("mr_gnt", {31'd0, bus.p0_gnt}, 32'd1);
      tick();
      bus.p0_req = 0;
      #1 chk("mr_pre_rvalid", {31'd0, bus.p0_rvalid}, 32'd1);
      rst = 1'b0;
      #1;
      chk("mr_rvalid", {31'd0, bus.p0_rvalid}, 32'd0);
      chk("mr_rdata0", bus.p0_rdata, 32'd0);
      chk("mr_rdata1", bus.p1_rdata, 32'd0);
      @(negedge clk) rst = 1'b1;
      tick();
      bus.p0_req = 1; bus.p0_addr = 32'h10;
      bus.p1_req = 1; bus.p1_addr = 32'h20;
      #1 chk("mr_first", {30'd0, bus.p1_gnt, bus.p0_gnt}, 32'd1);
      tick();
      idle_all();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
